spi_cmd_ctrl: RTL and testbench
===============================

SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Parameters
REQ-001 FRAME_W, default 16, SPI frame width in bits (equals MASTER_FRAME_WIDTH).
REQ-002 N_LED, default 8, number of PWM-driven LED channels.
REQ-003 DUTY_W, default 8, PWM duty register width.

Interface
REQ-004 sysclk  in  1  system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 cs  in  1  SPI chip select, already synchronised to sysclk; active-low.
REQ-007 rx_valid  in  1  single-cycle pulse: rx_frame holds a complete received frame.
REQ-008 rx_frame  in  FRAME_W  received frame: [15:12] opcode, [11:8] addr, [7:0] data.
REQ-009 tx_ack  in  1  single-cycle pulse: SPI slave has latched tx_frame.
REQ-010 slv_tx_enb  out  1  response pending; held high until tx_ack or abort.
REQ-011 tx_frame  out  FRAME_W  response frame to SPI slave.
REQ-012 duty  out  N_LED*DUTY_W  per-LED duty; channel i at bits [i*DUTY_W +: DUTY_W].
REQ-013 led_en  out  N_LED  per-LED enable mask to the PWM stage.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 err_cnt  out  8  count of rejected frames.

Function
REQ-016 FSM states: IDLE, DECODE, EXEC, RESP_WAIT; one-hot or binary at implementer choice.
REQ-017 IDLE: rx_valid=1 -> capture rx_frame into cmd register, next DECODE; otherwise stay.
REQ-018 DECODE, one cycle: classify opcode/addr, next EXEC.
REQ-019 Opcodes: 0x1 WR_DUTY duty[addr]<=data; 0x2 RD_DUTY reply {0x2,addr,duty[addr]}; 0x3 WR_ALL all duty<=data; 0x4 WR_EN led_en<=data[N_LED-1:0]; 0x5 RD_STAT reply {0x5,0x0,err_cnt}; 0x6 CLR_ERR err_cnt<=0; 0x0 NOP, no effect.
REQ-020 Opcodes 0x7-0xF, or addr>=N_LED on 0x1/0x2, are errors: no register change, err_cnt increments, no reply.
REQ-021 EXEC, one cycle: commit write (0x1,0x3,0x4,0x6), then IDLE; for 0x2/0x5, load tx_frame, set slv_tx_enb, then RESP_WAIT.
REQ-022 Write latency: rx_valid in cycle N -> new duty/led_en/err_cnt visible in cycle N+3.
REQ-023 Read latency: rx_valid in cycle N -> slv_tx_enb=1 and tx_frame valid from cycle N+3.
REQ-024 RESP_WAIT: tx_ack=1 -> clear slv_tx_enb, next IDLE; tx_frame stays stable while slv_tx_enb=1.
REQ-025 Abort: cs high in RESP_WAIT -> clear slv_tx_enb, next IDLE; err_cnt increments.
REQ-026 Overrun: rx_valid while state is not IDLE -> frame dropped, err_cnt increments, FSM unaffected.
REQ-027 Simultaneous error sources in one cycle increment err_cnt by 1 only.
REQ-028 err_cnt saturates at 0xFF; increments at 0xFF are discarded.
REQ-029 CLR_ERR takes precedence over a same-cycle increment; result is 0.
REQ-030 tx_ack outside RESP_WAIT is ignored.

Reset
REQ-031 rst_n low, asynchronously: state IDLE, slv_tx_enb=0, tx_frame=0, duty all 0, led_en all 0, err_cnt=0, busy=0.
REQ-032 Reset deassertion takes effect on the next sysclk edge; a frame in flight is discarded.

Verification
REQ-033 rx_frame=0x1380 pulse -> duty[3]=0x80 at N+3; all other channels unchanged.
REQ-034 WR_EN 0x40FF, then RD_DUTY 0x2300 -> slv_tx_enb at N+3, tx_frame=0x2380; tx_ack -> slv_tx_enb=0, busy=0 next cycle.
REQ-035 rx_frame=0x1A55 (addr 10) and 0x9000 -> no duty change, err_cnt=2, no slv_tx_enb.
REQ-036 Second rx_valid one cycle after the first -> first executes, second dropped, err_cnt=1.
REQ-037 RD_STAT, then cs high before tx_ack -> slv_tx_enb=0, state IDLE, err_cnt increments.
REQ-038 rst_n low during RESP_WAIT -> all outputs at reset values immediately, without a clock edge; 256 errors -> err_cnt holds 0xFF.

Source files
------------

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: command decoder between an SPI slave and a PWM LED stage.
// Received frames ({opcode, addr, data}) are captured, decoded and executed.
// Writes update the per-LED duty registers, the enable mask or the error
// counter. Reads load a response frame and hold it until the SPI slave
// acknowledges it or the master aborts by raising chip select.
//
// Ports:
//   sysclk     - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   cs         - SPI chip select (active-low, synchronised)
//   rx_valid   - single-cycle pulse, rx_frame holds a complete frame
//   rx_frame   - received frame: [15:12] opcode, [11:8] addr, [7:0] data
//   tx_ack     - single-cycle pulse, SPI slave has latched tx_frame
//   slv_tx_enb - response pending
//   tx_frame   - response frame
//   duty       - per-LED duty, channel i at [i*DUTY_W +: DUTY_W]
//   led_en     - per-LED enable mask
//   busy       - FSM not idle
//   err_cnt    - saturating count of rejected frames
module spi_cmd_ctrl #(
    parameter int unsigned FRAME_W = 16,
    parameter int unsigned N_LED   = 8,
    parameter int unsigned DUTY_W  = 8
) (
    input  logic                      sysclk,
    input  logic                      rst_n,
    input  logic                      cs,
    input  logic                      rx_valid,
    input  logic [FRAME_W-1:0]        rx_frame,
    input  logic                      tx_ack,
    output logic                      slv_tx_enb,
    output logic [FRAME_W-1:0]        tx_frame,
    output logic [N_LED*DUTY_W-1:0]   duty,
    output logic [N_LED-1:0]          led_en,
    output logic                      busy,
    output logic [7:0]                err_cnt
);

    localparam int unsigned IDX_W = (N_LED > 1) ? $clog2(N_LED) : 1;

    typedef enum logic [1:0] {StIdle, StDecode, StExec, StRespWait} state_e;

    state_e               r_state;
    state_e               w_state_nxt;

    logic [FRAME_W-1:0]   r_cmd;
    logic                 r_cmd_err;
    logic                 r_slv_tx_enb;
    logic [FRAME_W-1:0]   r_tx_frame;
    logic [DUTY_W-1:0]    r_duty [N_LED];
    logic [N_LED-1:0]     r_led_en;
    logic [7:0]           r_err_cnt;
    logic [7:0]           w_err_cnt_nxt;

    logic [3:0]           w_op;
    logic [3:0]           w_addr;
    logic [7:0]           w_data;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_addr_ok;
    logic                 w_exec_ok;
    logic                 w_is_read;
    logic                 w_err_inc;
    logic                 w_err_clr;

    assign w_op      = r_cmd[15:12];
    assign w_addr    = r_cmd[11:8];
    assign w_data    = r_cmd[7:0];
    assign w_idx     = r_cmd[8 +: IDX_W];
    assign w_addr_ok = ({28'd0, w_addr} < N_LED);
    assign w_exec_ok = (r_state == StExec) && !r_cmd_err;
    assign w_is_read = (w_op == 4'h2) || (w_op == 4'h5);

    // Overrun, rejected command and abort can coincide; each cycle counts once.
    assign w_err_inc = (rx_valid && (r_state != StIdle))
                     || ((r_state == StExec) && r_cmd_err)
                     || ((r_state == StRespWait) && cs && !tx_ack);
    assign w_err_clr = w_exec_ok && (w_op == 4'h6);

    always_comb begin
        w_err_cnt_nxt = r_err_cnt;
        if (w_err_clr) begin
            w_err_cnt_nxt = 8'h00;
        end else if (w_err_inc && (r_err_cnt != 8'hFF)) begin
            w_err_cnt_nxt = r_err_cnt + 8'h01;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:     if (rx_valid) w_state_nxt = StDecode;
            StDecode:   w_state_nxt = StExec;
            StExec:     w_state_nxt = (w_exec_ok && w_is_read) ? StRespWait : StIdle;
            // A same-cycle tx_ack completes the transfer, so it is not an abort.
            StRespWait: if (tx_ack || cs) w_state_nxt = StIdle;
            default:    w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd        <= '0;
            r_cmd_err    <= 1'b0;
            r_slv_tx_enb <= 1'b0;
            r_tx_frame   <= '0;
            r_led_en     <= '0;
            r_err_cnt    <= 8'h00;
            for (int i = 0; i < int'(N_LED); i++) begin
                r_duty[i] <= '0;
            end
        end else begin
            r_err_cnt <= w_err_cnt_nxt;
            if ((r_state == StIdle) && rx_valid) begin
                r_cmd <= rx_frame;
            end
            if (r_state == StDecode) begin
                r_cmd_err <= (w_op >= 4'h7)
                          || (((w_op == 4'h1) || (w_op == 4'h2)) && !w_addr_ok);
            end
            if (w_exec_ok) begin
                case (w_op)
                    4'h1: r_duty[w_idx] <= DUTY_W'(w_data);
                    4'h2: begin
                        r_tx_frame   <= FRAME_W'({4'h2, w_addr, 8'(r_duty[w_idx])});
                        r_slv_tx_enb <= 1'b1;
                    end
                    4'h3: begin
                        for (int i = 0; i < int'(N_LED); i++) begin
                            r_duty[i] <= DUTY_W'(w_data);
                        end
                    end
                    4'h4: r_led_en <= N_LED'(w_data);
                    4'h5: begin
                        r_tx_frame   <= FRAME_W'({4'h5, 4'h0, r_err_cnt});
                        r_slv_tx_enb <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if ((r_state == StRespWait) && (tx_ack || cs)) begin
                r_slv_tx_enb <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < int'(N_LED); g++) begin : g_duty
        assign duty[g*DUTY_W +: DUTY_W] = r_duty[g];
    end

    assign slv_tx_enb = r_slv_tx_enb;
    assign tx_frame   = r_tx_frame;
    assign led_en     = r_led_en;
    assign err_cnt    = r_err_cnt;
    assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: each vector carries a hand-computed
// expected value; all comparisons go through check_eq.
module tb_spi_cmd_ctrl;

    logic        sysclk;
    logic        rst_n;
    logic        cs;
    logic        rx_valid;
    logic [15:0] rx_frame;
    logic        tx_ack;
    logic        slv_tx_enb;
    logic [15:0] tx_frame;
    logic [63:0] duty;
    logic [7:0]  led_en;
    logic        busy;
    logic [7:0]  err_cnt;

    int n_tests;
    int n_fail;

    spi_cmd_ctrl #(
        .FRAME_W (16),
        .N_LED   (8),
        .DUTY_W  (8)
    ) u_dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .cs         (cs),
        .rx_valid   (rx_valid),
        .rx_frame   (rx_frame),
        .tx_ack     (tx_ack),
        .slv_tx_enb (slv_tx_enb),
        .tx_frame   (tx_frame),
        .duty       (duty),
        .led_en     (led_en),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // One-cycle rx_valid pulse; returns 1 unit after the capturing edge.
    task automatic send(input logic [15:0] f);
        rx_frame = f;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Full write command: returns when the result is visible (cycle N+3).
    task automatic send_wr(input logic [15:0] f);
        send(f);
        tick();
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_enb"},  64'(slv_tx_enb), 64'h0);
        check_eq({tag, "_tx"},   64'(tx_frame),   64'h0);
        check_eq({tag, "_duty"}, duty,            64'h0);
        check_eq({tag, "_led"},  64'(led_en),     64'h0);
        check_eq({tag, "_busy"}, 64'(busy),       64'h0);
        check_eq({tag, "_err"},  64'(err_cnt),    64'h0);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        cs       = 1'b0;
        rx_valid = 1'b0;
        rx_frame = 16'h0000;
        tx_ack   = 1'b0;

        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single-channel write with exact latency.
        send(16'h1380);
        check_eq("wr_busy", 64'(busy), 64'h1);
        tick();
        check_eq("wr_early", duty, 64'h0);
        tick();
        check_eq("wr_duty3", duty, 64'h00000000_80000000);
        check_eq("wr_idle", 64'(busy), 64'h0);

        // Enable mask, then read back channel 3.
        send_wr(16'h40FF);
        check_eq("wren_ff", 64'(led_en), 64'hFF);
        send(16'h2300);
        tick();
        check_eq("rd_early", 64'(slv_tx_enb), 64'h0);
        tick();
        check_eq("rd_enb", 64'(slv_tx_enb), 64'h1);
        check_eq("rd_frame", 64'(tx_frame), 64'h2380);
        tick();
        tick();
        check_eq("rd_hold_enb", 64'(slv_tx_enb), 64'h1);
        check_eq("rd_hold_frame", 64'(tx_frame), 64'h2380);
        check_eq("rd_hold_busy", 64'(busy), 64'h1);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        check_eq("ack_enb", 64'(slv_tx_enb), 64'h0);
        check_eq("ack_busy", 64'(busy), 64'h0);

        // Broadcast, then highest valid channel.
        send_wr(16'h3011);
        check_eq("wr_all", duty, 64'h11111111_11111111);
        send_wr(16'h1722);
        check_eq("wr_duty7", duty, 64'h22111111_11111111);
        send(16'h2700);
        tick();
        tick();
        check_eq("rd7_frame", 64'(tx_frame), 64'h2722);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;

        // Rejected frames: addr out of range, bad opcode, read of addr 8.
        send_wr(16'h1A55);
        send_wr(16'h9000);
        check_eq("err_two", 64'(err_cnt), 64'h2);
        send_wr(16'h2800);
        check_eq("err_rd8", 64'(err_cnt), 64'h3);
        check_eq("err_noenb", 64'(slv_tx_enb), 64'h0);
        check_eq("err_duty", duty, 64'h22111111_11111111);
        check_eq("err_idle", 64'(busy), 64'h0);

        send_wr(16'h4005);
        check_eq("wren_05", 64'(led_en), 64'h05);
        send_wr(16'h6000);
        check_eq("clr_err", 64'(err_cnt), 64'h0);

        // Overrun: second frame one cycle after the first is dropped.
        rx_frame = 16'h1044;
        rx_valid = 1'b1;
        tick();
        rx_frame = 16'h1055;
        tick();
        rx_valid = 1'b0;
        tick();
        check_eq("ovr_duty", duty, 64'h22111111_11111144);
        check_eq("ovr_err", 64'(err_cnt), 64'h1);

        // Status read aborted by cs.
        send(16'h5000);
        tick();
        tick();
        check_eq("stat_frame", 64'(tx_frame), 64'h5001);
        cs = 1'b1;
        tick();
        cs = 1'b0;
        check_eq("abort_enb", 64'(slv_tx_enb), 64'h0);
        check_eq("abort_busy", 64'(busy), 64'h0);
        check_eq("abort_err", 64'(err_cnt), 64'h2);

        // tx_ack while idle has no effect.
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        check_eq("ack_idle_busy", 64'(busy), 64'h0);
        check_eq("ack_idle_err", 64'(err_cnt), 64'h2);

        // Asynchronous reset in RESP_WAIT, checked between clock edges.
        send(16'h2000);
        tick();
        tick();
        check_eq("pre_rst_frame", 64'(tx_frame), 64'h2044);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        tick();
        rst_n = 1'b1;
        tick();

        // CLR_ERR beats a same-cycle overrun increment.
        send_wr(16'hF000);
        check_eq("err_f", 64'(err_cnt), 64'h1);
        send(16'h6000);
        tick();
        rx_frame = 16'h9999;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check_eq("clr_prec", 64'(err_cnt), 64'h0);
        tick();
        check_eq("clr_prec_idle", 64'(busy), 64'h0);

        // Abort and overrun in the same cycle count once.
        send(16'h5000);
        tick();
        tick();
        check_eq("stat0_frame", 64'(tx_frame), 64'h5000);
        cs = 1'b1;
        rx_frame = 16'h1000;
        rx_valid = 1'b1;
        tick();
        cs = 1'b0;
        rx_valid = 1'b0;
        check_eq("dual_err", 64'(err_cnt), 64'h1);
        check_eq("dual_enb", 64'(slv_tx_enb), 64'h0);

        // Saturation.
        for (int i = 0; i < 254; i++) begin
            send_wr(16'h8000);
        end
        check_eq("sat_ff", 64'(err_cnt), 64'hFF);
        for (int i = 0; i < 3; i++) begin
            send_wr(16'h8000);
        end
        check_eq("sat_hold", 64'(err_cnt), 64'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
